// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shift unit: operation encodings.
package shift_pkg;

  // Operation select carried with each operand through the pipeline.
  typedef enum logic [1:0] {
    MODE_SHR  = 2'b00,  // logical right, zero fill
    MODE_SHL  = 2'b01,  // logical left, zero fill
    MODE_ASHR = 2'b10,  // arithmetic right, sign fill
    MODE_ROR  = 2'b11   // rotate right
  } shift_mode_e;

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the shift unit: conditionally shifts by 2^STAGE and
// registers the result with its sideband. The last stage also applies the
// out-of-range override for shift amounts >= DATAWIDTH.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   en                       advance; registers hold when 0
//   prev_*                   payload from the previous stage (or the input)
//   valid, data, mode,
//   sign, ovf, amt           registered payload for the next stage
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned NSTAGES   = 4,
  parameter int unsigned STAGE     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 prev_valid,
  input  logic [DATAWIDTH-1:0] prev_data,
  input  shift_mode_e          prev_mode,
  input  logic                 prev_sign,
  input  logic                 prev_ovf,
  input  logic [NSTAGES-1:0]   prev_amt,
  output logic                 valid,
  output logic [DATAWIDTH-1:0] data,
  output shift_mode_e          mode,
  output logic                 sign,
  output logic                 ovf,
  output logic [NSTAGES-1:0]   amt
);

  localparam int unsigned STEP = 32'(1) << STAGE;
  localparam int unsigned BACK = DATAWIDTH - STEP;
  localparam bit          LAST = (STAGE == NSTAGES - 1);

  logic [DATAWIDTH-1:0] fill;
  logic [DATAWIDTH-1:0] shifted;
  logic [DATAWIDTH-1:0] nxt;

  // Conditional 2^STAGE shift, then the overflow override on the last stage.
  // Rotation needs no override: the low amount bits already give amt mod width.
  always_comb begin
    fill    = {DATAWIDTH{prev_sign}};
    shifted = prev_data;
    if (prev_amt[STAGE]) begin
      case (prev_mode)
        MODE_SHR:  shifted = prev_data >> STEP;
        MODE_SHL:  shifted = prev_data << STEP;
        MODE_ASHR: shifted = (prev_data >> STEP) | (fill << BACK);
        MODE_ROR:  shifted = (prev_data >> STEP) | (prev_data << BACK);
        default:   shifted = prev_data;
      endcase
    end
    nxt = shifted;
    if (LAST && prev_ovf) begin
      case (prev_mode)
        MODE_SHR,
        MODE_SHL:  nxt = '0;
        MODE_ASHR: nxt = fill;
        default:   nxt = shifted;
      endcase
    end
  end

  // Stage register with hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      mode  <= MODE_SHR;
      sign  <= 1'b0;
      ovf   <= 1'b0;
      amt   <= '0;
    end else if (en) begin
      valid <= prev_valid;
      data  <= nxt;
      mode  <= prev_mode;
      sign  <= prev_sign;
      ovf   <= prev_ovf;
      amt   <= prev_amt;
    end
  end

endmodule

// File: rtl/shift_unit.sv
// Pipelined barrel shifter (SHR/SHL/ASHR/ROR) with valid/ready handshake on
// both sides. One stage per shift-amount bit; latency NSTAGES, one result
// per cycle. The whole pipeline stalls when the output is held.
// Ports:
//   Clk, Rst                 clock, synchronous active-high reset
//   a, sh_amt, mode          operand, unsigned shift amount, operation
//   in_valid / in_ready      input handshake
//   d, out_valid / out_ready result and output handshake
module shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned NSTAGES   = $clog2(DATAWIDTH)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] sh_amt,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] d,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic                 advance;
  logic                 v    [NSTAGES+1];
  logic [DATAWIDTH-1:0] data [NSTAGES+1];
  shift_mode_e          md   [NSTAGES+1];
  logic                 sgn  [NSTAGES+1];
  logic                 ovf  [NSTAGES+1];
  logic [NSTAGES-1:0]   amt  [NSTAGES+1];

  // Whole pipeline moves together unless a valid result is being held.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Pipeline entry: out-of-range flag is taken from the high amount bits here.
  assign v[0]    = in_valid;
  assign data[0] = a;
  assign md[0]   = shift_mode_e'(mode);
  assign sgn[0]  = a[DATAWIDTH-1];
  assign ovf[0]  = |sh_amt[DATAWIDTH-1:NSTAGES];
  assign amt[0]  = sh_amt[NSTAGES-1:0];

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    shift_stage #(
      .DATAWIDTH (DATAWIDTH),
      .NSTAGES   (NSTAGES),
      .STAGE     (k)
    ) u_stage (
      .clk        (Clk),
      .rst        (Rst),
      .en         (advance),
      .prev_valid (v[k]),
      .prev_data  (data[k]),
      .prev_mode  (md[k]),
      .prev_sign  (sgn[k]),
      .prev_ovf   (ovf[k]),
      .prev_amt   (amt[k]),
      .valid      (v[k+1]),
      .data       (data[k+1]),
      .mode       (md[k+1]),
      .sign       (sgn[k+1]),
      .ovf        (ovf[k+1]),
      .amt        (amt[k+1])
    );
  end

  assign d         = data[NSTAGES];
  assign out_valid = v[NSTAGES];

  // Sideband leaving the last stage has no consumer.
  logic unused_tail;
  assign unused_tail = ^{md[NSTAGES], sgn[NSTAGES], ovf[NSTAGES], amt[NSTAGES]};

endmodule

// File: tb/tb_shift_unit.sv
module tb_shift_unit;
  import shift_pkg::*;

  localparam int unsigned DW  = 16;
  localparam int          LAT = 4;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [DW-1:0] a;
  logic [DW-1:0] sh_amt;
  logic [1:0]    mode;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] d;
  logic          out_valid;
  logic          out_ready;

  shift_unit #(.DATAWIDTH(DW)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .a         (a),
    .sh_amt    (sh_amt),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] res;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  int            cyc      = 0;
  int            n_in     = 0;
  int            n_out    = 0;
  bit            rst_seen = 1'b0;
  bit            stalled  = 1'b0;
  logic [DW-1:0] held     = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: the shift rules stated directly in integer arithmetic.
  function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] x, input int amt,
                                              input logic [1:0] m);
    logic [2*DW-1:0] dbl;
    case (m)
      MODE_SHR:  return (amt >= DW) ? '0 : x >> amt;
      MODE_SHL:  return (amt >= DW) ? '0 : x << amt;
      MODE_ASHR: return (amt >= DW) ? {DW{x[DW-1]}} : DW'($signed(x) >>> amt);
      default: begin
        dbl = {x, x};
        return DW'(dbl >> (amt % DW));
      end
    endcase
  endfunction

  // Scoreboard: inputs and outputs are stable at the falling edge, so the
  // handshakes seen here are the ones that complete at the next rising edge.
  always @(negedge Clk) begin
    exp_t e;
    cyc++;
    if (Rst) begin
      exp_q.delete();
      stalled  = 1'b0;
      rst_seen = 1'b1;
    end else begin
      if (rst_seen) begin
        chk("post_reset_out_valid", 64'(out_valid), 64'(0));
        chk("post_reset_d", 64'(d), 64'(0));
        rst_seen = 1'b0;
      end
      chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (stalled) begin
        chk("stall_valid_held", 64'(out_valid), 64'(1));
        chk("stall_d_held", 64'(d), 64'(held));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'(d), 64'(0));
          chk("unexpected_output_valid", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("result", 64'(d), 64'(e.res));
          chk("latency_min", 64'(cyc - e.cyc >= LAT), 64'(1));
        end
      end
      stalled = out_valid && !out_ready;
      held    = d;
      if (in_valid && in_ready) begin
        n_in++;
        exp_q.push_back('{ref_shift(a, int'(sh_amt), mode), cyc});
      end
    end
  end

  // Single transfer into an idle pipeline; checks result and exact latency.
  task automatic send_one(input string name, input logic [DW-1:0] av, input int amt,
                          input logic [1:0] m, input logic [DW-1:0] expv);
    int n = 0;
    a = av; sh_amt = DW'(amt); mode = m; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(LAT));
    chk(name, 64'(d), 64'(expv));
    @(posedge Clk); #1;
  endtask

  // Offer one input and hold it until accepted (bounded).
  task automatic push(input logic [DW-1:0] av, input int amt, input logic [1:0] m);
    int n = 0;
    a = av; sh_amt = DW'(amt); mode = m; in_valid = 1'b1;
    do begin
      @(negedge Clk);
      n++;
    end while (!in_ready && n < 50);
    chk("push_accepted", 64'(in_ready), 64'(1));
    @(posedge Clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'(0));
    @(posedge Clk); #1;
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int out0;
    int base;
    int cycles;

    Rst = 1'b1; in_valid = 1'b0; a = '0; sh_amt = '0; mode = 2'b00; out_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    @(posedge Clk); #1;

    // Pin the reference against hand-computed values.
    chk("model_shr", 64'(ref_shift(16'hF0F0, 4, MODE_SHR)), 64'(16'h0F0F));
    chk("model_ashr_ovf", 64'(ref_shift(16'h8000, 20, MODE_ASHR)), 64'(16'hFFFF));
    chk("model_ror_ovf", 64'(ref_shift(16'h1234, 20, MODE_ROR)), 64'(16'h4123));

    // Directed vectors with literal expectations.
    send_one("shr_f0f0_4",    16'hF0F0, 4,  MODE_SHR,  16'h0F0F);
    send_one("ashr_8001_1",   16'h8001, 1,  MODE_ASHR, 16'hC000);
    send_one("ashr_8000_20",  16'h8000, 20, MODE_ASHR, 16'hFFFF);
    send_one("shl_0001_16",   16'h0001, 16, MODE_SHL,  16'h0000);
    send_one("ror_0001_1",    16'h0001, 1,  MODE_ROR,  16'h8000);
    send_one("ror_1234_20",   16'h1234, 20, MODE_ROR,  16'h4123);
    send_one("shl_0001_15",   16'h0001, 15, MODE_SHL,  16'h8000);
    send_one("ashr_7000_20",  16'h7000, 20, MODE_ASHR, 16'h0000);
    send_one("shr_ffff_40",   16'hFFFF, 40, MODE_SHR,  16'h0000);
    send_one("ror_1234_16",   16'h1234, 16, MODE_ROR,  16'h1234);
    send_one("shr_abcd_0",    16'hABCD, 0,  MODE_SHR,  16'hABCD);
    send_one("ashr_8421_15",  16'h8421, 15, MODE_ASHR, 16'hFFFF);

    // Six back-to-back inputs with a three-cycle output stall.
    out0 = n_out;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++)
          push(DW'(32'h1357 * (i + 1)), i * 3, 2'(i % 4));
      end
      begin
        int n = 0;
        while (!out_valid && n < 50) begin
          @(negedge Clk);
          n++;
        end
        @(posedge Clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge Clk);
          chk("stall_in_ready_low", 64'(in_ready), 64'(0));
          chk("stall_out_valid", 64'(out_valid), 64'(1));
        end
        @(posedge Clk); #1;
        out_ready = 1'b1;
      end
    join
    drain("stall_drain");
    chk("stall_delivered", 64'(n_out - out0), 64'(6));

    // Reset with three transfers in flight, plus an input offered during reset.
    for (int i = 0; i < 3; i++)
      push(16'hFFFF, i, MODE_SHR);
    Rst = 1'b1; in_valid = 1'b1; a = 16'hFFFF; sh_amt = 16'd1; mode = MODE_SHR;
    @(posedge Clk); #1;
    Rst = 1'b0; in_valid = 1'b0;
    out0 = n_out;
    @(negedge Clk);
    chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
    chk("rst_mid_d", 64'(d), 64'(0));
    chk("rst_mid_in_ready", 64'(in_ready), 64'(1));
    repeat (12) @(negedge Clk);
    chk("rst_no_stale_results", 64'(n_out - out0), 64'(0));
    @(posedge Clk); #1;

    // Random regression with random input/output throttling.
    base = n_in;
    cycles = 0;
    while (n_in - base < 10000 && cycles < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      a         = DW'($urandom);
      sh_amt    = DW'($urandom_range(0, 40));
      mode      = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge Clk); #1;
      cycles++;
    end
    chk("rand_transfers", 64'(n_in - base >= 10000), 64'(1));
    drain("rand_drain");
    chk("total_in_out", 64'(n_out), 64'(n_in - 3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
